branch_resolve_bht: RTL
=======================

// Module: branch_resolve_bht
// PURPOSE
// - Consumer end of the branch comparator: drives its brUn select, takes brEq/brLt back, resolves BEQ..BGEU.
// - Holds a direct-mapped 2-bit branch history table (BHT) that gives fetch its taken/not-taken prediction.
// - Raises mispredict plus redirect_pc for the pipeline flush, and keeps saturating performance counters.
// PARAMETERS
// - IDX_W  6   BHT index width; 2**IDX_W entries, indexed by pc[IDX_W+1:2]
// - XLEN   32  PC/address width
// PORTS
// - clk          in   1     single clock, rising edge
// - rst_n        in   1     asynchronous, active-low reset
// - if_pc        in   XLEN  fetch PC to predict
// - if_pred      out  1     prediction for if_pc = MSB of its BHT counter (combinational read)
// - ex_valid     in   1     EX stage holds a valid instruction
// - ex_is_br     in   1     EX instruction is a conditional branch
// - ex_funct3    in   3     branch funct3
// - ex_pc        in   XLEN  branch PC
// - ex_target    in   XLEN  branch target (pc+imm, computed upstream)
// - ex_pred      in   1     prediction carried down the pipe with this branch
// - brUn         out  1     to comparator: 1 = unsigned compare; = ex_funct3[1]
// - brEq, brLt   in   1     from comparator, same cycle
// - ex_taken     out  1     resolved outcome
// - illegal_br   out  1     ex_valid & ex_is_br & funct3 in {010,011}
// - mispredict   out  1     ex_valid & ex_is_br & (ex_taken != ex_pred)
// - redirect_pc  out  XLEN  ex_taken ? ex_target : ex_pc+4 (mod 2**XLEN)
// - clr_stats    in   1     synchronous clear of both statistics counters
// - br_cnt       out  32    count of resolved legal branches
// - mispred_cnt  out  32    count of mispredicts (legal and illegal branches)
// BEHAVIOUR
// - Resolve (combinational): 000 taken=brEq; 001 taken=~brEq; 100/110 taken=brLt; 101/111 taken=~brLt; 010/011 taken=0.
// - ex_taken, mispredict and illegal_br are 0 whenever ~(ex_valid & ex_is_br). brUn always follows ex_funct3[1].
// - BHT update: at the posedge where ex_valid & ex_is_br & ~illegal_br, BHT[ex_pc idx] changes.
//   - Taken: increment, saturating at 2'b11. Not taken: decrement, saturating at 2'b00.
//   - Illegal branches never update the table.
// - Read/write same index in one cycle: if_pred returns the pre-update value (no bypass). The new value is visible on the next cycle.
// - Encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
// - Statistics, per cycle:
//   - br_cnt += 1 on a legal resolve.
//   - mispred_cnt += 1 on mispredict.
//   - Both saturate at 32'hFFFF_FFFF.
//   - clr_stats wins over a simultaneous increment: result is 0.
// - Reset (async, rst_n low): every BHT entry = 2'b01; br_cnt = mispred_cnt = 0.
//   - All other outputs are combinational from inputs; if_pred therefore reads 0 during reset.
//   - Reset asserted mid-operation takes effect immediately. An update pending at that edge is discarded.
// - Latency: resolve, mispredict and redirect are 0-cycle. Table and counters update 1 cycle later.
// STRUCTURE
// - Package rv_branch_pkg:
//   - funct3 constants F3_BEQ/BNE/BLT/BGE/BLTU/BGEU
//   - BHT encodings BHT_SNT/WNT/WT/ST, with BHT_RESET = BHT_WNT
// - Sub-module br_cond_eval (combinational): funct3, brEq, brLt -> taken, illegal.
// - The top holds the BHT flop array, the saturating update logic and the statistics counters.
// TESTING
// - Reset: pulse rst_n low -> for every index, if_pred=0 and BHT=01; br_cnt=mispred_cnt=0.
// - BEQ (000), brEq=1, ex_pred=0, ex_pc=0x100, ex_target=0x140:
//   - Same cycle: ex_taken=1, mispredict=1, redirect_pc=0x140, brUn=0.
//   - Next cycle: if_pc=0x100 gives if_pred=1; br_cnt=1, mispred_cnt=1.
// - BLTU (110), brLt=0, ex_pred=1, ex_pc=0x200 -> brUn=1, ex_taken=0, mispredict=1, redirect_pc=0x204.
// - Saturation: 4 taken BNE at 0x300 -> counter 11; then 1 not-taken -> 10, if_pred stays 1.
//   - Next 2 not-taken -> 00; further not-taken stays 00.
// - Illegal funct3 010 with ex_pred=1 -> illegal_br=1, ex_taken=0, mispredict=1.
//   - Table unchanged; br_cnt unchanged; mispred_cnt+1.
// - Corner cases:
//   - clr_stats together with a mispredict -> both counters read 0 next cycle.
//   - Preload br_cnt to 0xFFFFFFFF (force), then a branch -> br_cnt stays 0xFFFFFFFF.
//   - Drop rst_n mid-update -> table returns to 01 with no posedge needed.

Source files
------------

// File: rtl/branch_resolve_bht_pkg.sv
// Shared branch-resolve definitions: funct3 codes, BHT counter encodings and
// the saturating helpers used by the BHT and the statistics counters.
package rv_branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    BHT_SNT = 2'b00,
    BHT_WNT = 2'b01,
    BHT_WT  = 2'b10,
    BHT_ST  = 2'b11
  } bht_state_e;

  localparam bht_state_e BHT_RESET = BHT_WNT;

  // Two-bit saturating step toward the resolved direction.
  function automatic bht_state_e bht_next(input bht_state_e cur, input logic taken);
    bht_state_e nxt;
    nxt = cur;
    case (cur)
      BHT_SNT: nxt = taken ? BHT_WNT : BHT_SNT;
      BHT_WNT: nxt = taken ? BHT_WT  : BHT_SNT;
      BHT_WT:  nxt = taken ? BHT_ST  : BHT_WNT;
      BHT_ST:  nxt = taken ? BHT_ST  : BHT_WT;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_bht_if.sv
// Bundle of fetch-prediction, EX-resolve, comparator and statistics signals
// between the pipeline (master) and the branch resolve/BHT block (slave).
interface branch_resolve_bht_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] if_pc;
  logic            if_pred;
  logic            ex_valid;
  logic            ex_is_br;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred;
  logic            brUn;
  logic            brEq;
  logic            brLt;
  logic            ex_taken;
  logic            illegal_br;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic            clr_stats;
  logic [31:0]     br_cnt;
  logic [31:0]     mispred_cnt;

  modport slave (
    input  if_pc, ex_valid, ex_is_br, ex_funct3, ex_pc, ex_target, ex_pred,
           brEq, brLt, clr_stats,
    output if_pred, brUn, ex_taken, illegal_br, mispredict, redirect_pc,
           br_cnt, mispred_cnt
  );

  modport master (
    output if_pc, ex_valid, ex_is_br, ex_funct3, ex_pc, ex_target, ex_pred,
           brEq, brLt, clr_stats,
    input  if_pred, brUn, ex_taken, illegal_br, mispredict, redirect_pc,
           br_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_bht_cond_eval.sv
// Combinational branch condition evaluation from funct3 and the comparator
// flags; funct3 010/011 are not branch encodings and are flagged illegal.
module br_cond_eval
  import rv_branch_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_br_eq,
  input  logic       i_br_lt,
  output logic       o_taken,
  output logic       o_illegal
);

  always_comb begin
    o_taken   = 1'b0;
    o_illegal = 1'b0;
    case (i_funct3)
      F3_BEQ:           o_taken = i_br_eq;
      F3_BNE:           o_taken = ~i_br_eq;
      F3_BLT, F3_BLTU:  o_taken = i_br_lt;
      F3_BGE, F3_BGEU:  o_taken = ~i_br_lt;
      default:          o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_bht.sv
// Branch resolve stage with a direct-mapped 2-bit BHT for fetch prediction,
// mispredict/redirect generation and saturating branch statistics.
module branch_resolve_bht
  import rv_branch_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int XLEN  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_resolve_bht_if.slave  bus
);

  localparam int ENTRIES = 2 ** IDX_W;

  bht_state_e       r_bht [ENTRIES];
  logic [31:0]      r_br_cnt;
  logic [31:0]      r_mispred_cnt;

  logic             w_br_active;
  logic             w_cond_taken;
  logic             w_cond_illegal;
  logic             w_taken;
  logic             w_legal_resolve;
  logic             w_mispredict;
  logic [IDX_W-1:0] w_if_idx;
  logic [IDX_W-1:0] w_ex_idx;
  logic             w_unused_pc_bits;

  br_cond_eval u_cond (
    .i_funct3  (bus.ex_funct3),
    .i_br_eq   (bus.brEq),
    .i_br_lt   (bus.brLt),
    .o_taken   (w_cond_taken),
    .o_illegal (w_cond_illegal)
  );

  assign w_br_active     = bus.ex_valid & bus.ex_is_br;
  assign w_taken         = w_br_active & w_cond_taken;
  assign w_legal_resolve = w_br_active & ~w_cond_illegal;
  assign w_mispredict    = w_br_active & (w_taken != bus.ex_pred);

  assign w_if_idx = bus.if_pc[IDX_W+1:2];
  assign w_ex_idx = bus.ex_pc[IDX_W+1:2];
  assign w_unused_pc_bits = ^{bus.if_pc[XLEN-1:IDX_W+2], bus.if_pc[1:0]};

  assign bus.brUn        = bus.ex_funct3[1];
  assign bus.ex_taken    = w_taken;
  assign bus.illegal_br  = w_br_active & w_cond_illegal;
  assign bus.mispredict  = w_mispredict;
  assign bus.redirect_pc = w_taken ? bus.ex_target : bus.ex_pc + XLEN'(4);

  // Fetch sees the pre-update counter when it reads the index being trained.
  assign bus.if_pred = r_bht[w_if_idx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_bht[i] <= BHT_RESET;
      end
    end else if (w_legal_resolve) begin
      r_bht[w_ex_idx] <= bht_next(r_bht[w_ex_idx], w_taken);
    end
  end

  // A clear in the same cycle as an increment leaves both counters at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_cnt      <= 32'd0;
      r_mispred_cnt <= 32'd0;
    end else if (bus.clr_stats) begin
      r_br_cnt      <= 32'd0;
      r_mispred_cnt <= 32'd0;
    end else begin
      if (w_legal_resolve) begin
        r_br_cnt <= sat_inc32(r_br_cnt);
      end
      if (w_mispredict) begin
        r_mispred_cnt <= sat_inc32(r_mispred_cnt);
      end
    end
  end

  assign bus.br_cnt      = r_br_cnt;
  assign bus.mispred_cnt = r_mispred_cnt;

endmodule
